data_mem_responder: RTL



---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 101 ++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Processor data-bus and transmit-stream signals shared by the memory responder
// and whatever drives it.
interface data_mem_responder_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output MemWrite, Addr, WriteData, out_ready,
    input  ReadData, out_data, out_valid
  );

  modport slave (
    input  MemWrite, Addr, WriteData, out_ready,
    output ReadData, out_data, out_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus an MMIO window holding a byte
// transmit FIFO, its status/overflow flags and a free-running cycle counter.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int FIFO_LOG2  = 4
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int          FIFO_DEPTH  = 1 << FIFO_LOG2;
  localparam int          CW          = FIFO_LOG2 + 1;
  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_0008;

  logic [31:0]           mem [1 << DEPTH_LOG2];
  logic [7:0]            fifo [FIFO_DEPTH];
  logic [FIFO_LOG2-1:0]  wr_ptr;
  logic [FIFO_LOG2-1:0]  rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic [31:0]           cycles;

  logic                  sel_ram;
  logic                  sel_tx;
  logic                  sel_status;
  logic                  sel_cycles;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  full;
  logic                  empty;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic [31:0]           status_word;
  logic                  unused_bits;

  // Byte offset within a word is ignored for every region, MMIO included.
  assign sel_ram    = bus.Addr[31:16] == 16'h0000;
  assign sel_tx     = bus.Addr[31:2] == TXDATA_ADDR[31:2];
  assign sel_status = bus.Addr[31:2] == STATUS_ADDR[31:2];
  assign sel_cycles = bus.Addr[31:2] == CYCLES_ADDR[31:2];
  assign word_idx   = bus.Addr[DEPTH_LOG2+1:2];
  assign unused_bits = ^{bus.Addr[1:0], bus.WriteData[31:8]};

  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign push_req = bus.MemWrite && sel_tx;
  assign push     = push_req && !full;
  assign pop      = !empty && bus.out_ready;

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 8'h00 : fifo[rd_ptr];

  always_comb begin
    status_word          = '0;
    status_word[0]       = full;
    status_word[1]       = empty;
    status_word[2]       = overflow;
    status_word[4 +: CW] = count;
  end

  always_comb begin
    bus.ReadData = '0;
    if (sel_ram)
      bus.ReadData = mem[word_idx];
    else if (sel_status)
      bus.ReadData = status_word;
    else if (sel_cycles)
      bus.ReadData = cycles;
  end

  // Storage arrays carry data only and are never cleared.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && sel_ram)
      mem[word_idx] <= bus.WriteData;
    if (push)
      fifo[wr_ptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cycles   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push_req && full)
        overflow <= 1'b1;
      else if (bus.MemWrite && sel_status && bus.WriteData[2])
        overflow <= 1'b0;
      cycles <= (bus.MemWrite && sel_cycles) ? 32'd0 : cycles + 32'd1;
    end
  end
endmodule
